// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg
//   Shared definitions for the RAM burst initiators: FSM state encoding and
//   the address / length width helpers, so a future writer can reuse them.
//   No ports.

package ram_burst_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_t;

  // Address width for a RAM of 'depth' words (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Length width: one extra bit so a full-depth burst is representable.
  function automatic int len_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if
//   Bundles the burst request, the RAM read port and the valid/ready output
//   stream of the burst reader.
//   master : the reader (drives r_addr, rd_en, out_data, out_valid, busy, done)
//   slave  : the surrounding system (drives start, base_addr, burst_len,
//            mem_data, out_ready)

interface ram_burst_reader_if #(
  parameter int length    = 4,
  parameter int locations = 8
) ();

  localparam int aw = ram_burst_reader_pkg::addr_width(locations);
  localparam int lw = ram_burst_reader_pkg::len_width(locations);

  logic              start;
  logic [aw-1:0]     base_addr;
  logic [lw-1:0]     burst_len;
  logic [aw-1:0]     r_addr;
  logic              rd_en;
  logic [length-1:0] mem_data;
  logic [length-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, burst_len, mem_data, out_ready,
    output r_addr, rd_en, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, burst_len, mem_data, out_ready,
    input  r_addr, rd_en, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/ram_burst_reader_out_stage_reg.sv
// ram_burst_reader_out_stage_reg
//   One-entry valid/ready output register.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_data and mark valid
//   load_data  : word to capture
//   consume    : downstream handshake (valid && ready) this cycle
//   data/valid : registered output word and its valid flag

module ram_burst_reader_out_stage_reg #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             consume,
  output logic [width-1:0] data,
  output logic             valid
);

  // A load in the same cycle as a consume replaces the outgoing word, so
  // valid stays high and the stream runs at one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Walks the RAM read port from a base address for a programmed number of
//   words (wrapping modulo the depth) and streams them out through a
//   one-entry valid/ready register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request (start, base_addr, burst_len), RAM read port
//              (r_addr, rd_en, mem_data), stream (out_data, out_valid,
//              out_ready), status (busy, done)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; base/length captured on start
//   READ  | rd_en high; a word is loaded whenever the output slot frees
//   FLUSH | last word loaded; waiting for it to be accepted
//   DONE  | one-cycle done pulse, then back to IDLE

module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int length    = 4,
  parameter int locations = 8
) (
  input logic                clk,
  input logic                rst,
  ram_burst_reader_if.master bus
);

  localparam int aw = addr_width(locations);
  localparam int lw = len_width(locations);
  localparam logic [aw-1:0] last_addr = aw'(locations - 1);
  localparam logic [lw-1:0] max_len   = lw'(locations);

  state_t            state;
  state_t            state_nx;
  logic [aw-1:0]     r_addr_q;
  logic [lw-1:0]     remaining;
  logic              capture;
  logic              load;
  logic              consume;
  logic [length-1:0] out_data;
  logic              out_valid;

  assign consume = out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_len != '0) begin
            capture  = 1'b1;
            state_nx = READ;
          end else begin
            state_nx = DONE;
          end
        end
      end
      READ: begin
        load = (!out_valid || bus.out_ready) && (remaining != '0);
        if (load && (remaining == lw'(1))) begin
          state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (consume) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Address and remaining-word down-counter only move on a load, so both
  // hold while the output slot is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q  <= '0;
      remaining <= '0;
    end else if (capture) begin
      r_addr_q  <= bus.base_addr;
      remaining <= (bus.burst_len > max_len) ? max_len : bus.burst_len;
    end else if (load) begin
      r_addr_q  <= (r_addr_q == last_addr) ? '0 : r_addr_q + aw'(1);
      remaining <= remaining - lw'(1);
    end
  end

  ram_burst_reader_out_stage_reg #(
    .width (length)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (bus.mem_data),
    .consume   (consume),
    .data      (out_data),
    .valid     (out_valid)
  );

  assign bus.r_addr    = r_addr_q;
  assign bus.rd_en     = (state == READ);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;

endmodule
